instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset; all state SHALL change only on the rising edge of CLK.
REQ-002 The block SHALL have these ports:
- CLK  in  1  system clock
- RST_N  in  1  synchronous active-low reset
- Addr  in  8  current fetch address from the upstream program counter (counter register + 1)
- MemData  in  8  instruction byte at Addr
- MemValid  in  1  MemData valid this cycle
- PL  out  8  parallel-load value to the program counter
- PL_E  out  1  program-counter load enable (counter register <= PL, so the next Addr = PL+1)
- Opcode  out  8  registered opcode of the issued instruction
- Operand  out  8  registered operand (8'h00 for one-byte instructions)
- InstValid  out  1  Opcode/Operand hold a valid instruction
- InstReady  in  1  downstream accepts the instruction when InstValid=1 and InstReady=1

Function
REQ-003 Instruction format SHALL be: Opcode[7]=0 means a one-byte instruction; Opcode[7]=1 means two bytes, with the operand at the next address.
REQ-004 The FSM SHALL have states START, FETCH_OP and FETCH_ARG; reset SHALL force START, and START SHALL always move to FETCH_OP on the next clock.
REQ-005 PL and PL_E SHALL be combinational: PL_E=1 and PL=8'hFF while RST_N=0 or in START, so the first fetch address is 8'h00.
REQ-006 The output slot SHALL be free when InstValid=0 or InstReady=1; a handshake SHALL clear InstValid at the edge unless a new instruction loads in the same cycle.
REQ-007 In FETCH_OP with MemValid=1 and Opcode[7]=0 and the slot free, the block SHALL load Opcode=MemData, Operand=8'h00 and InstValid=1 at the edge, stay in FETCH_OP and leave PL_E=0.
REQ-008 In FETCH_OP with MemValid=1 and Opcode[7]=1, the block SHALL latch the opcode internally, go to FETCH_ARG and leave PL_E=0; the slot does not need to be free for this step.
REQ-009 In FETCH_ARG with MemValid=1 and the slot free, the block SHALL load the latched opcode and Operand=MemData, set InstValid=1 and return to FETCH_OP.
REQ-010 Stall: in FETCH_OP or FETCH_ARG, if MemValid=0 or a needed slot is not free, the block SHALL drive PL_E=1 and PL=Addr-1 (mod 256) and SHALL NOT consume MemData.
REQ-011 Address arithmetic SHALL be 8-bit modulo 256: a stall at Addr=8'h00 SHALL drive PL=8'hFF, and a fetch at Addr=8'hFF SHALL continue at 8'h00.
REQ-012 While InstValid=1 and InstReady=0, Opcode and Operand SHALL stay stable.
REQ-013 Each fetched byte SHALL be consumed exactly once, and no instruction SHALL be dropped or duplicated.

Reset
REQ-014 When RST_N=0 at a clock edge, the block SHALL set state=START, InstValid=0, Opcode=8'h00, Operand=8'h00 and the internal opcode latch to 8'h00.
REQ-015 A reset in any state, including FETCH_ARG mid-instruction, SHALL discard the partial instruction and any pending output.
REQ-016 The first Addr after reset is released SHALL be 8'h00.

Configuration
REQ-017 Macro IFETCH_JUMP_EN SHALL control jump handling for opcode 8'hF0 (JMP, two bytes).
REQ-018 With IFETCH_JUMP_EN defined:
- in FETCH_ARG with the latched opcode 8'hF0 and MemValid=1, the block SHALL drive PL_E=1 and PL=MemData-1 (mod 256);
- it SHALL return to FETCH_OP without loading the output slot, and this step SHALL not require a free slot;
- the next Addr SHALL be the target.
REQ-019 Without IFETCH_JUMP_EN, 8'hF0 SHALL be an ordinary two-byte instruction passed downstream per REQ-009.

Verification
REQ-020 Reset, then MemData 01 at Addr 00 and 02 at Addr 01, MemValid=1, InstReady=1 -> Opcode 01 with Operand 00, then Opcode 02, each with InstValid=1 for one cycle, and PL_E=0 after START.
REQ-021 Bytes 85 at Addr 03 and 3C at Addr 04 -> a single InstValid with Opcode 85 and Operand 3C, and the next Addr is 05.
REQ-022 MemValid=0 for 3 cycles at Addr 05 -> PL_E=1 and PL=04 each cycle, Addr stays 05, and InstValid does not rise for new data.
REQ-023 InstReady=0 with InstValid=1 while a one-byte opcode waits -> PL_E=1, PL=Addr-1 and Opcode stable; on InstReady=1 the next instruction issues in the following cycle.
REQ-024 With IFETCH_JUMP_EN, bytes F0 at Addr 10 and 20 at Addr 11 -> PL_E=1 and PL=1F, next Addr=20, and no InstValid for the JMP; without the macro -> Opcode F0 and Operand 20 are issued.
REQ-025 RST_N=0 for one cycle in FETCH_ARG -> InstValid=0, PL_E=1 with PL=FF, and fetch restarts at Addr 00 with no stale opcode issued.

Source files
------------

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch -- byte-serial instruction fetch stage.
//
// Consumes one instruction byte per cycle from the memory port. It assembles
// one-byte (Opcode[7]=0) and two-byte (Opcode[7]=1, operand at the next
// address) instructions and presents them in a valid/ready output slot.
// Stalls are implemented by steering the upstream program counter back to
// the current address. The counter holds Addr-1, so loading PL=Addr-1 makes
// the same Addr reappear next cycle.
//
// Ports:
//   CLK        in   system clock (rising edge)
//   RST_N      in   synchronous active-low reset
//   Addr       in   [7:0] current fetch address (upstream counter + 1)
//   MemData    in   [7:0] instruction byte at Addr
//   MemValid   in   MemData is valid this cycle
//   PL         out  [7:0] parallel-load value for the program counter
//   PL_E       out  program-counter load enable (combinational)
//   Opcode     out  [7:0] registered opcode of the issued instruction
//   Operand    out  [7:0] registered operand (8'h00 for one-byte instructions)
//   InstValid  out  Opcode/Operand hold a valid instruction
//   InstReady  in   downstream accepts when InstValid && InstReady
//
// Build option:
//   IFETCH_JUMP_EN  when defined, opcode 8'hF0 (two bytes) is a jump. It is
//                   resolved here by loading the counter with target-1, and
//                   it is never passed downstream. When undefined, 8'hF0 is
//                   an ordinary two-byte instruction.
// -----------------------------------------------------------------------------
module instr_fetch (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [7:0] Addr,
  input  logic [7:0] MemData,
  input  logic       MemValid,
  output logic [7:0] PL,
  output logic       PL_E,
  output logic [7:0] Opcode,
  output logic [7:0] Operand,
  output logic       InstValid,
  input  logic       InstReady
);

  typedef enum logic [1:0] {
    START     = 2'd0,
    FETCH_OP  = 2'd1,
    FETCH_ARG = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] op_latch_q, op_latch_d;
  logic [7:0] opcode_q, opcode_d;
  logic [7:0] operand_q, operand_d;
  logic       inst_valid_q, inst_valid_d;
  logic       slot_free;

  // The slot can take a new instruction if it is empty or is being drained
  // in this same cycle.
  assign slot_free = !inst_valid_q || InstReady;

  always_comb begin
    state_d      = state_q;
    op_latch_d   = op_latch_q;
    opcode_d     = opcode_q;
    operand_d    = operand_q;
    // A completed handshake empties the slot unless a load below refills it.
    inst_valid_d = inst_valid_q && !InstReady;
    PL_E         = 1'b0;
    // Stall value: Addr-1 keeps the same address on the bus next cycle.
    PL           = Addr - 8'd1;

    unique case (state_q)
      START: begin
        // Counter <= FF, so the first fetch address is 00.
        PL_E    = 1'b1;
        PL      = 8'hFF;
        state_d = FETCH_OP;
      end

      FETCH_OP: begin
        if (MemValid && MemData[7]) begin
          // First byte of a two-byte instruction. It is held internally, so
          // the output slot does not need to be free yet.
          op_latch_d = MemData;
          state_d    = FETCH_ARG;
        end else if (MemValid && slot_free) begin
          opcode_d     = MemData;
          operand_d    = 8'h00;
          inst_valid_d = 1'b1;
        end else begin
          PL_E = 1'b1;
        end
      end

      FETCH_ARG: begin
`ifdef IFETCH_JUMP_EN
        if (MemValid && (op_latch_q == 8'hF0)) begin
          // Jump resolved locally: the next Addr becomes the target.
          PL_E    = 1'b1;
          PL      = MemData - 8'd1;
          state_d = FETCH_OP;
        end else if (MemValid && slot_free) begin
`else
        if (MemValid && slot_free) begin
`endif
          opcode_d     = op_latch_q;
          operand_d    = MemData;
          inst_valid_d = 1'b1;
          state_d      = FETCH_OP;
        end else begin
          PL_E = 1'b1;
        end
      end

      default: begin
        PL_E    = 1'b1;
        PL      = 8'hFF;
        state_d = START;
      end
    endcase

    // Reset overrides the counter load so that fetching restarts at 00.
    if (!RST_N) begin
      PL_E = 1'b1;
      PL   = 8'hFF;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q      <= START;
      op_latch_q   <= 8'h00;
      opcode_q     <= 8'h00;
      operand_q    <= 8'h00;
      inst_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_latch_q   <= op_latch_d;
      opcode_q     <= opcode_d;
      operand_q    <= operand_d;
      inst_valid_q <= inst_valid_d;
    end
  end

  assign Opcode    = opcode_q;
  assign Operand   = operand_q;
  assign InstValid = inst_valid_q;

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch -- randomized self-checking bench for instr_fetch.
//
// The bench models the upstream program counter and a random program memory.
// The reference model walks the program from address 00 and lists the
// instructions that the program defines, with jumps resolved when
// IFETCH_JUMP_EN is defined. Every accepted handshake must match the next
// instruction of that list, whatever the stall pattern is.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [7:0] Addr;
  logic [7:0] MemData;
  logic       MemValid;
  logic [7:0] PL;
  logic       PL_E;
  logic [7:0] Opcode;
  logic [7:0] Operand;
  logic       InstValid;
  logic       InstReady;

  logic [7:0] mem [256];
  logic [7:0] cnt_q = 8'h00;

  int checks   = 0;
  int failures = 0;

  instr_fetch dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .Addr      (Addr),
    .MemData   (MemData),
    .MemValid  (MemValid),
    .PL        (PL),
    .PL_E      (PL_E),
    .Opcode    (Opcode),
    .Operand   (Operand),
    .InstValid (InstValid),
    .InstReady (InstReady)
  );

  always #5 CLK = ~CLK;

  // Upstream program counter: it loads PL on PL_E and otherwise counts up.
  assign Addr    = cnt_q + 8'd1;
  assign MemData = mem[Addr];
  always @(posedge CLK) cnt_q <= PL_E ? PL : cnt_q + 8'd1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: returns the next instruction that the program defines.
  logic [7:0] model_pc;
  task automatic model_next(output logic [7:0] op, output logic [7:0] arg);
    logic [7:0] nxt;
    op  = 8'h00;
    arg = 8'h00;
    for (int guard = 0; guard < 512; guard++) begin
      op = mem[model_pc];
      if (!op[7]) begin
        arg      = 8'h00;
        model_pc = model_pc + 8'd1;
        break;
      end
      nxt = model_pc + 8'd1;
      arg = mem[nxt];
`ifdef IFETCH_JUMP_EN
      if (op == 8'hF0) begin
        model_pc = arg;
        continue;
      end
`endif
      model_pc = model_pc + 8'd2;
      break;
    end
  endtask

  logic hold_prev;
  logic [7:0] prev_op, prev_arg;

  task automatic do_reset(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge CLK);
      RST_N     = 1'b0;
      MemValid  = 1'($urandom);
      InstReady = 1'($urandom);
      #1;
      check_eq("rst_pl_e", PL_E, 1);
      check_eq("rst_pl", PL, 8'hFF);
    end
    @(negedge CLK);
    #1;
    check_eq("rst_valid", InstValid, 0);
    check_eq("rst_opcode", Opcode, 8'h00);
    check_eq("rst_operand", Operand, 8'h00);
    // Release reset. This cycle is START and must not consume MemData.
    RST_N     = 1'b1;
    MemValid  = 1'b1;
    InstReady = 1'b1;
    #1;
    check_eq("start_pl_e", PL_E, 1);
    check_eq("start_pl", PL, 8'hFF);
    model_pc  = 8'h00;
    hold_prev = 1'b0;
  endtask

  initial begin
    logic [7:0] eo, ea, exp_pl;
    int hs;
    int len;
    RST_N     = 1'b0;
    MemValid  = 1'b0;
    InstReady = 1'b0;
    hold_prev = 1'b0;
    prev_op   = 8'h00;
    prev_arg  = 8'h00;
    model_pc  = 8'h00;

    for (int seg = 0; seg < 8; seg++) begin
      for (int i = 0; i < 256; i++) begin
        mem[i] = 8'($urandom);
        if ($urandom_range(0, 15) == 0) mem[i] = 8'hF0;
      end
      if (seg == 0) begin
        mem[8'h00] = 8'h01; mem[8'h01] = 8'h02; mem[8'h02] = 8'h04;
        mem[8'h03] = 8'h85; mem[8'h04] = 8'h3C; mem[8'h05] = 8'h06;
        mem[8'h06] = 8'h7F; mem[8'h07] = 8'h10; mem[8'h08] = 8'h10;
        mem[8'h09] = 8'h10; mem[8'h10] = 8'hF0; mem[8'h11] = 8'h20;
      end

      // Single-cycle resets land mid-instruction, including in FETCH_ARG.
      do_reset((seg % 2 == 0) ? 2 : 1);

      hs  = 0;
      len = (seg == 0) ? 700 : $urandom_range(40, 700);
      for (int cyc = 0; cyc < len; cyc++) begin
        @(negedge CLK);
        MemValid  = ($urandom_range(0, 99) < 75);
        InstReady = ($urandom_range(0, 99) < 70);
        #1;
        if (cyc == 0) check_eq("first_addr", Addr, 8'h00);
        if (!MemValid) begin
          exp_pl = Addr - 8'd1;
          check_eq("stall_pl_e", PL_E, 1);
          check_eq("stall_pl", PL, exp_pl);
        end
        if (hold_prev) begin
          check_eq("hold_valid", InstValid, 1);
          check_eq("hold_opcode", Opcode, prev_op);
          check_eq("hold_operand", Operand, prev_arg);
        end
        if (InstValid && InstReady) begin
          model_next(eo, ea);
          check_eq("issue_opcode", Opcode, eo);
          check_eq("issue_operand", Operand, ea);
          hs++;
        end
        hold_prev = InstValid && !InstReady;
        prev_op   = Opcode;
        prev_arg  = Operand;
      end
      check_eq("progress", (hs > 0) ? 1 : 0, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
